// File: rtl/lzw_dictionary_arbiter_pkg.sv
// Shared constants, state encoding and entry helpers for the LZW dictionary
// arbiter and its pending-write FIFO.
package lzw_dictionary_arbiter_pkg;

  localparam int DICT_DEPTH = 16384;
  localparam int ROOT_NUM   = 256;
  localparam int CODE_W     = 14;
  localparam int BYTE_W     = 8;
  localparam int ENTRY_W    = 23;
  localparam int FIFO_W     = CODE_W + BYTE_W;

  localparam logic [CODE_W-1:0] CODE_ONE   = CODE_W'(1);
  localparam logic [CODE_W-1:0] FIRST_CODE = CODE_W'(ROOT_NUM);
  localparam logic [CODE_W-1:0] LAST_ROOT  = CODE_W'(ROOT_NUM - 1);
  localparam logic [CODE_W-1:0] LAST_CODE  = CODE_W'(DICT_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } dict_state_e;

  // Root codes map to themselves: valid bit, null prefix, the byte value.
  function automatic logic [ENTRY_W-1:0] root_entry(input logic [BYTE_W-1:0] k);
    return {1'b1, {CODE_W{1'b0}}, k};
  endfunction

  function automatic logic [ENTRY_W-1:0] new_entry(input logic [FIFO_W-1:0] e);
    return {1'b1, e};
  endfunction

endpackage

// File: rtl/lzw_dict_wr_fifo.sv
// Pending dictionary-write FIFO: {prefix, byte} entries, show-ahead read,
// synchronous flush. Storage is not reset; only the pointers are.
module lzw_dict_wr_fifo
  import lzw_dictionary_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rst,
  input  logic              flush,
  input  logic              push,
  input  logic [FIFO_W-1:0] push_data,
  input  logic              pop,
  output logic [FIFO_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [FIFO_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // Extra MSB on each pointer distinguishes full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lzw_dictionary_arbiter.sv
// Arbitrates a single-port LZW dictionary RAM between the init sweep,
// lookup reads (always priority) and queued new-entry writes.
module lzw_dictionary_arbiter
  import lzw_dictionary_arbiter_pkg::*;
#(
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic               I_sys_clk,
  input  logic               I_sys_rst,
  input  logic               I_state_clr,
  input  logic               I_dict_clr,
  input  logic               I_rd_slot,
  input  logic [CODE_W-1:0]  I_rd_addr,
  output logic [ENTRY_W-1:0] O_rd_dout,
  input  logic               I_wr_valid,
  output logic               O_wr_ready,
  input  logic [CODE_W-1:0]  I_wr_prefix,
  input  logic [BYTE_W-1:0]  I_wr_byte,
  output logic [CODE_W-1:0]  O_ram_addr,
  output logic [ENTRY_W-1:0] O_ram_din,
  output logic               O_ram_wren,
  input  logic [ENTRY_W-1:0] I_ram_dout,
  output logic               O_busy,
  output logic [CODE_W-1:0]  O_next_code,
  output logic               O_dict_full,
  output logic [15:0]        O_drop_cnt
);

  dict_state_e       state_q;
  dict_state_e       state_d;
  logic [CODE_W-1:0] sweep_addr_q;
  logic [CODE_W-1:0] sweep_addr_d;
  logic [CODE_W-1:0] next_code_q;
  logic              dict_full_q;
  logic [15:0]       drop_cnt_q;

  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_dout;

  logic              pop_vld_p0;
  logic              wr_vld_p0;
  logic              drop_vld_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign O_busy      = (state_q != ST_RUN);
  assign O_wr_ready  = (state_q == ST_RUN) && !fifo_full;
  assign O_next_code = next_code_q;
  assign O_dict_full = dict_full_q;
  assign O_drop_cnt  = drop_cnt_q;
  assign O_rd_dout   = I_ram_dout;

  // An entry offered alongside a dictionary clear belongs to the old dictionary.
  assign fifo_push = I_wr_valid && O_wr_ready && !I_dict_clr;

  lzw_dict_wr_fifo #(
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .I_sys_clk (I_sys_clk),
    .I_sys_rst (I_sys_rst),
    .flush     (I_dict_clr),
    .push      (fifo_push),
    .push_data ({I_wr_prefix, I_wr_byte}),
    .pop       (pop_vld_p0),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---- p0: slot decision, made combinationally from registered state ----
  assign pop_vld_p0  = (state_q == ST_RUN) && !I_rd_slot && !fifo_empty;
  assign wr_vld_p0   = pop_vld_p0 && !dict_full_q;
  assign drop_vld_p0 = pop_vld_p0 && dict_full_q;

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    O_ram_addr   = I_rd_addr;
    O_ram_din    = '0;
    O_ram_wren   = 1'b0;
    case (state_q)
      ST_INIT: begin
        O_ram_wren   = 1'b1;
        O_ram_addr   = sweep_addr_q;
        O_ram_din    = root_entry(sweep_addr_q[BYTE_W-1:0]);
        sweep_addr_d = sweep_addr_q + CODE_ONE;
        if (sweep_addr_q == LAST_ROOT) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        O_ram_wren   = 1'b1;
        O_ram_addr   = sweep_addr_q;
        sweep_addr_d = sweep_addr_q + CODE_ONE;
        if (sweep_addr_q == LAST_CODE) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wr_vld_p0) begin
          O_ram_wren = 1'b1;
          O_ram_addr = next_code_q;
          O_ram_din  = new_entry(fifo_dout);
        end
      end
      default: begin
        state_d      = ST_INIT;
        sweep_addr_d = '0;
      end
    endcase
  end

  // ---- p1: registered control state ----
  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst || I_dict_clr) begin
      state_q      <= ST_INIT;
      sweep_addr_q <= '0;
      next_code_q  <= FIRST_CODE;
      dict_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      // The last code stays visible once written; the full flag stops further writes.
      if (wr_vld_p0) begin
        if (next_code_q == LAST_CODE) dict_full_q <= 1'b1;
        else                          next_code_q <= next_code_q + CODE_ONE;
      end
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst || I_state_clr) drop_cnt_q <= 16'd0;
    else if (drop_vld_p0)         drop_cnt_q <= sat_inc16(drop_cnt_q);
  end

endmodule
